// File: rtl/scpu_pkg.sv
// Shared definitions for the scalar CPU front end: data width, the NOP
// encoding and the fetch FSM state type.
package scpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage : scpu_pkg

// File: rtl/fetch_fifo.sv
// Prefetch queue holding {pc, ins} pairs. Writes are synchronous, the head is
// read combinationally, and the valid flag is a register so that nothing
// downstream sees a combinational path from pop to head_valid.
//
// Handshake: a word leaves the queue at a rising edge where head_valid and
// pop are both high; push writes the tail at the same edge. flush empties
// the queue and overrides any push or pop in that cycle.
module fetch_fifo
  import scpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [XLEN-1:0]       push_pc,
  input  logic [XLEN-1:0]       push_ins,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [XLEN-1:0]       head_pc,
  output logic [XLEN-1:0]       head_ins,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic [PW:0]       count_next;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && head_valid && !flush;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  // Pointers, occupancy and the registered valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      count      <= count_next;
      head_valid <= (count_next != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; the pointers define what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_pc, push_ins};
  end

  assign head_pc  = head_valid ? mem[rd_ptr][2*XLEN-1:XLEN] : '0;
  assign head_ins = head_valid ? mem[rd_ptr][XLEN-1:0]      : '0;
  assign level    = count;

  // The issue throttle upstream must keep a push from landing on a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    do_push |-> (count != FULL_LVL));

endmodule : fetch_fifo

// File: rtl/ins_fetch.sv
// Instruction fetch front end: issues sequential PCs to a one-cycle-latency
// instruction buffer, tracks the single in-flight word, and queues returned
// {pc, ins} pairs for decode. A redirect reloads the PC and drops everything
// in flight or queued.
//
// Handshake toward decode: out_valid/out_ready, a word is consumed at a rising
// edge where both are high; out_valid never depends on out_ready in the same
// cycle.
module ins_fetch
  import scpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0,
  parameter int              PC_INC   = 1,
  parameter int              DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  output logic [XLEN-1:0]        pc_out,
  input  logic [XLEN-1:0]        ins_in,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_ins,
  output logic [XLEN-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] level,
  output fetch_state_e           state_dbg
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

  fetch_state_e    state;
  logic            pend_v;
  logic [XLEN-1:0] pend_pc;
  logic            issue;

  // Counting the in-flight word against capacity guarantees it has a slot.
  assign issue = (state == RUN) && !redirect_valid &&
                 ((int'(level) + int'(pend_v)) < DEPTH);

  // Run/idle FSM, request PC and the in-flight (pending) word tracker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pc_out  <= RESET_PC;
      pend_v  <= 1'b0;
      pend_pc <= '0;
    end else begin
      state <= fetch_en ? RUN : IDLE;
      if (redirect_valid) begin
        pc_out <= redirect_pc;
        pend_v <= 1'b0;
      end else if (issue) begin
        pc_out  <= pc_out + PC_STEP;
        pend_v  <= 1'b1;
        pend_pc <= pc_out;
      end else begin
        pend_v <= 1'b0;
      end
    end
  end

  assign state_dbg = state;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (pend_v),
    .push_pc    (pend_pc),
    .push_ins   (ins_in),
    .pop        (out_ready),
    .head_valid (out_valid),
    .head_pc    (out_pc),
    .head_ins   (out_ins),
    .level      (level)
  );

endmodule : ins_fetch
